// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module   : mem_bus_arbiter_if
// Purpose  : Requester-side and shared-bus signal bundle for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  m0_req;
   logic                  m1_req;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [31:0]           m0_wdata;
   logic [31:0]           m1_wdata;
   logic [3:0]            m0_wmask;
   logic [3:0]            m1_wmask;
   logic [31:0]           m0_rdata;
   logic [31:0]           m1_rdata;
   logic                  m0_done;
   logic                  m1_done;
   logic                  m0_err;
   logic                  m1_err;

   logic                  s_access;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wmask;
   logic                  s_rstrb;
   logic [31:0]           s_rdata;
   logic                  s_rbusy;
   logic                  s_wbusy;

   // Arbiter view: owns the shared bus and the requester responses.
   modport master (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  m0_wmask, m1_wmask,
      output m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
      output s_access, s_addr, s_wdata, s_wmask, s_rstrb,
      input  s_rdata, s_rbusy, s_wbusy
   );

   modport slave (
      output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
      output m0_wmask, m1_wmask,
      input  m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
      input  s_access, s_addr, s_wdata, s_wmask, s_rstrb,
      output s_rdata, s_rbusy, s_wbusy
   );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Round-robin two-requester sequencer for the shared BRAM/IO bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mem_bus_arbiter_if.master bus,
   output logic              grant_id,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT_R = 3'd2,
      WAIT_W = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [8:0] c_read_latency = 9'(READ_LATENCY);
   localparam logic [8:0] c_timeout      = 9'(TIMEOUT_CYCLES);

   state_t                r_state;
   logic                  r_last_grant;
   logic [7:0]            r_count;
   logic                  r_is_write;

   logic                  w_any_req;
   logic                  w_sel;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [31:0]           w_wdata;
   logic [3:0]            w_wmask;
   logic                  w_lat_ok;
   logic                  w_timeout;

   // Ties go to whichever requester was not served last.
   always_comb begin
      w_any_req = bus.m0_req | bus.m1_req;
      if (bus.m0_req && bus.m1_req) begin
         w_sel = ~r_last_grant;
      end else begin
         w_sel = bus.m1_req;
      end
      w_addr    = w_sel ? bus.m1_addr  : bus.m0_addr;
      w_wdata   = w_sel ? bus.m1_wdata : bus.m0_wdata;
      w_wmask   = w_sel ? bus.m1_wmask : bus.m0_wmask;
      w_lat_ok  = ({1'b0, r_count} + 9'd1) >= c_read_latency;
      w_timeout = ({1'b0, r_count} + 9'd1) >= c_timeout;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_count      <= 8'd0;
         r_is_write   <= 1'b0;
         grant_id     <= 1'b0;
         busy         <= 1'b0;
         bus.s_access <= 1'b0;
         bus.s_addr   <= '0;
         bus.s_wdata  <= 32'd0;
         bus.s_wmask  <= 4'd0;
         bus.s_rstrb  <= 1'b0;
         bus.m0_rdata <= 32'd0;
         bus.m1_rdata <= 32'd0;
         bus.m0_done  <= 1'b0;
         bus.m1_done  <= 1'b0;
         bus.m0_err   <= 1'b0;
         bus.m1_err   <= 1'b0;
      end else begin
         bus.m0_done <= 1'b0;
         bus.m1_done <= 1'b0;
         bus.m0_err  <= 1'b0;
         bus.m1_err  <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  grant_id     <= w_sel;
                  busy         <= 1'b1;
                  bus.s_access <= 1'b1;
                  bus.s_addr   <= w_addr;
                  bus.s_wdata  <= w_wdata;
                  bus.s_wmask  <= w_wmask;
                  bus.s_rstrb  <= (w_wmask == 4'd0);
                  r_is_write   <= (w_wmask != 4'd0);
                  r_state      <= ISSUE;
               end
            end

            // Strobes drop after one cycle so a write is never replayed.
            ISSUE: begin
               bus.s_wmask <= 4'd0;
               bus.s_rstrb <= 1'b0;
               r_count     <= 8'd0;
               r_state     <= r_is_write ? WAIT_W : WAIT_R;
            end

            WAIT_R: begin
               if (w_lat_ok && !bus.s_rbusy) begin
                  if (grant_id) begin
                     bus.m1_rdata <= bus.s_rdata;
                     bus.m1_done  <= 1'b1;
                  end else begin
                     bus.m0_rdata <= bus.s_rdata;
                     bus.m0_done  <= 1'b1;
                  end
                  bus.s_access <= 1'b0;
                  r_state      <= DONE;
               end else if (w_timeout) begin
                  if (grant_id) begin
                     bus.m1_rdata <= 32'd0;
                     bus.m1_done  <= 1'b1;
                     bus.m1_err   <= 1'b1;
                  end else begin
                     bus.m0_rdata <= 32'd0;
                     bus.m0_done  <= 1'b1;
                     bus.m0_err   <= 1'b1;
                  end
                  bus.s_access <= 1'b0;
                  r_state      <= DONE;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end

            WAIT_W: begin
               if (!bus.s_wbusy || w_timeout) begin
                  if (grant_id) begin
                     bus.m1_done <= 1'b1;
                     bus.m1_err  <= bus.s_wbusy;
                  end else begin
                     bus.m0_done <= 1'b1;
                     bus.m0_err  <= bus.s_wbusy;
                  end
                  bus.s_access <= 1'b0;
                  r_state      <= DONE;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end

            DONE: begin
               r_last_grant <= grant_id;
               busy         <= 1'b0;
               r_state      <= IDLE;
            end

            default: begin
               bus.s_access <= 1'b0;
               bus.s_wmask  <= 4'd0;
               bus.s_rstrb  <= 1'b0;
               busy         <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed scoreboard bench for mem_bus_arbiter with a BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

   typedef struct {
      logic        id;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        grant_id;
   logic        busy;
   logic        rbusy = 1'b0;
   logic        wbusy = 1'b0;
   logic [31:0] mem [0:255];
   logic [31:0] mem_q;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [31:0] exp_rd [2];
   exp_t        exp_q [$];
   exp_t        mon_e;

   mem_bus_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   mem_bus_arbiter #(
      .ADDR_WIDTH    (32),
      .READ_LATENCY  (1),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .grant_id(grant_id),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: one-cycle read, byte-masked write; garbage while rbusy.
   assign bus.s_rbusy = rbusy;
   assign bus.s_wbusy = wbusy;
   assign bus.s_rdata = rbusy ? 32'hBAD0_BAD0 : mem_q;

   always @(posedge clk) begin
      if (!reset) begin
         mem[8'h40] <= 32'hDEAD_BEEF;
         mem[8'h10] <= 32'h0000_0000;
      end else begin
         if (bus.s_rstrb) mem_q <= mem[bus.s_addr[9:2]];
         if (bus.s_access && (bus.s_wmask != 4'd0)) begin
            for (int b = 0; b < 4; b++)
               if (bus.s_wmask[b]) mem[bus.s_addr[9:2]][8*b +: 8] <= bus.s_wdata[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.m0_done || bus.m1_done) begin
         chk("single_done", 32'(bus.m0_done & bus.m1_done), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("grant", 32'(bus.m1_done), 32'(mon_e.id));
            chk("rdata", bus.m1_done ? bus.m1_rdata : bus.m0_rdata, mon_e.rdata);
            chk("err", 32'(bus.m1_done ? bus.m1_err : bus.m0_err), 32'(mon_e.err));
            chk("other_err", 32'(bus.m1_done ? bus.m0_err : bus.m1_err), 32'd0);
            chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
      if ((bus.m0_err && !bus.m0_done) || (bus.m1_err && !bus.m1_done))
         chk("err_without_done", {30'd0, bus.m1_err, bus.m0_err}, {30'd0, bus.m1_done, bus.m0_done});
   end

   task automatic push(input logic id, input logic [31:0] rdata, input logic err, input int c);
      exp_t e;
      e.id = id; e.rdata = rdata; e.err = err; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic id, input logic req, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
      if (id) begin
         bus.m1_req = req; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wmask = wmask;
      end else begin
         bus.m0_req = req; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wmask = wmask;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_single(input logic id, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wmask, input logic [31:0] exp_rdata,
                             input logic exp_err, input int lat);
      drive(id, 1'b1, addr, wdata, wmask);
      push(id, exp_rdata, exp_err, cyc + lat);
      repeat (lat) step();
      drive(id, 1'b0, addr, wdata, wmask);
      wait_drain();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},   32'(busy), 32'd0);
      chk({tag, "_grant"},  32'(grant_id), 32'd0);
      chk({tag, "_access"}, 32'(bus.s_access), 32'd0);
      chk({tag, "_addr"},   bus.s_addr, 32'd0);
      chk({tag, "_wmask"},  32'(bus.s_wmask), 32'd0);
      chk({tag, "_rstrb"},  32'(bus.s_rstrb), 32'd0);
      chk({tag, "_rd0"},    bus.m0_rdata, 32'd0);
      chk({tag, "_rd1"},    bus.m1_rdata, 32'd0);
      chk({tag, "_done"},   {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
      chk({tag, "_err"},    {30'd0, bus.m1_err, bus.m0_err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b1;
      step();

      // Single read by requester 0.
      drive(1'b0, 1'b1, 32'h100, 32'd0, 4'd0);
      t = cyc;
      exp_rd[0] = 32'hDEAD_BEEF;
      push(1'b0, exp_rd[0], 1'b0, t + 3);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("rd_rstrb", 32'(bus.s_rstrb), 32'(cyc == t + 1));
         chk("rd_busy", 32'(busy), 32'(cyc >= t + 1 && cyc <= t + 3));
         if (cyc == t + 3) bus.m0_req = 1'b0;
      end
      wait_drain();
      chk("rd_m1_untouched", bus.m1_rdata, exp_rd[1]);

      // Single partial write by requester 1; strobe lasts one cycle only.
      drive(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
      t = cyc;
      push(1'b1, exp_rd[1], 1'b0, t + 3);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("wr_wmask", 32'(bus.s_wmask), (cyc == t + 1) ? 32'h3 : 32'h0);
         chk("wr_rstrb", 32'(bus.s_rstrb), 32'd0);
         if (cyc == t + 3) bus.m1_req = 1'b0;
      end
      wait_drain();
      exp_rd[1] = 32'h0000_5678;
      run_single(1'b1, 32'h40, 32'd0, 4'd0, exp_rd[1], 1'b0, 3);
      chk("wr_m0_untouched", bus.m0_rdata, exp_rd[0]);

      // Contention: both held, grants alternate 0,1,0,1 every 4 cycles.
      drive(1'b0, 1'b1, 32'h100, 32'd0, 4'd0);
      drive(1'b1, 1'b1, 32'h40, 32'd0, 4'd0);
      t = cyc;
      push(1'b0, 32'hDEAD_BEEF, 1'b0, t + 3);
      push(1'b1, 32'h0000_5678, 1'b0, t + 7);
      push(1'b0, 32'hDEAD_BEEF, 1'b0, t + 11);
      push(1'b1, 32'h0000_5678, 1'b0, t + 15);
      for (int k = 1; k <= 15; k++) begin
         step();
         if (cyc == t + 11) bus.m0_req = 1'b0;
         if (cyc == t + 15) bus.m1_req = 1'b0;
      end
      wait_drain();

      // rbusy held through five wait cycles; capture only after it drops.
      rbusy = 1'b1;
      drive(1'b0, 1'b1, 32'h40, 32'd0, 4'd0);
      t = cyc;
      exp_rd[0] = 32'h0000_5678;
      push(1'b0, exp_rd[0], 1'b0, t + 8);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (cyc == t + 7) rbusy = 1'b0;
         if (cyc == t + 8) bus.m0_req = 1'b0;
      end
      wait_drain();

      // Write timeout with wbusy stuck, then a normal access by requester 1.
      wbusy = 1'b1;
      run_single(1'b0, 32'h80, 32'hCAFE_F00D, 4'hF, exp_rd[0], 1'b1, 10);
      wbusy = 1'b0;
      chk("tmo_idle", 32'(busy), 32'd0);
      exp_rd[1] = 32'hDEAD_BEEF;
      run_single(1'b1, 32'h100, 32'd0, 4'd0, exp_rd[1], 1'b0, 3);

      // Read timeout clears the requester's read data.
      rbusy = 1'b1;
      exp_rd[0] = 32'd0;
      run_single(1'b0, 32'h100, 32'd0, 4'd0, exp_rd[0], 1'b1, 10);
      rbusy = 1'b0;

      // Reset in WAIT_R: everything clears at once and no done follows.
      rbusy = 1'b1;
      drive(1'b1, 1'b1, 32'h100, 32'd0, 4'd0);
      t = cyc;
      repeat (3) step();
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      rbusy = 1'b0;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("post_reset_idle", 32'(busy), 32'd0);

      // First tie after reset goes to requester 0.
      drive(1'b0, 1'b1, 32'h100, 32'd0, 4'd0);
      drive(1'b1, 1'b1, 32'h100, 32'd0, 4'd0);
      t = cyc;
      push(1'b0, 32'hDEAD_BEEF, 1'b0, t + 3);
      push(1'b1, 32'hDEAD_BEEF, 1'b0, t + 7);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (cyc == t + 3) bus.m0_req = 1'b0;
         if (cyc == t + 7) bus.m1_req = 1'b0;
      end
      wait_drain();
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter and sequencer for the SoC memory bus (BRAM plus IO space).
- Requester 0 is the FemtoRV32 core side; requester 1 is a DMA/firmware-loader engine.
- The block serialises accesses with round-robin grant and drives the single shared bus.
- It paces reads by a fixed latency plus rbusy, waits on wbusy for writes, and returns registered read data with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- READ_LATENCY, 1, minimum cycles after the rstrb cycle before rdata may be sampled (BRAM = 1); legal range 1..15.
- TIMEOUT_CYCLES, 255, maximum cycles spent in a wait state before the access is aborted with error; 8-bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1 each  request; held high with address, data and mask stable until the matching done pulse.
- m0_addr, m1_addr  in  ADDR_WIDTH each  byte address.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_wmask, m1_wmask  in  4 each  byte write mask; 0 = read, nonzero = write.
- m0_rdata, m1_rdata  out  32 each  registered read data.
- m0_done, m1_done  out  1 each  one-cycle completion pulse.
- m0_err, m1_err  out  1 each  one-cycle timeout pulse, coincident with done.
- s_access  out  1  shared-bus access qualifier.
- s_addr  out  ADDR_WIDTH  shared address.
- s_wdata  out  32  shared write data.
- s_wmask  out  4  shared write mask.
- s_rstrb  out  1  shared read strobe.
- s_rdata  in  32  shared read data.
- s_rbusy  in  1  read busy, active high.
- s_wbusy  in  1  write busy, active high.
- grant_id  out  1  requester currently or last granted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0: s_*, m*_rdata, m*_done, m*_err, grant_id, busy.
  - Reset during any state aborts the access; no done is issued.
- States: IDLE, ISSUE, WAIT_R, WAIT_W, DONE.
- IDLE:
  - s_access, s_rstrb and s_wmask are 0.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - Register grant_id and go to ISSUE. If no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - s_access=1; s_addr, s_wdata and s_wmask come from the granted requester.
  - s_rstrb=1 if wmask==0.
  - Next state is WAIT_R for a read, WAIT_W for a write.
  - Clear the wait counter.
- WAIT_R:
  - s_access=1, s_addr held, s_wmask=0, s_rstrb=0; counter increments each cycle.
  - When counter+1 >= READ_LATENCY and s_rbusy=0: capture s_rdata into m<g>_rdata and go to DONE.
- WAIT_W:
  - s_access=1, s_addr held, s_wmask=0 so the write is never repeated.
  - When s_wbusy=0, go to DONE.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES in WAIT_R or WAIT_W, go to DONE with an error flag set.
  - On a read timeout, m<g>_rdata = 32'h0.
- DONE (1 cycle):
  - m<g>_done=1, and m<g>_err=1 if timed out; s_access=0.
  - last_grant is set to grant_id; next state is IDLE.
- Latency:
  - Read, READ_LATENCY=1, rbusy low: req sampled in IDLE at cycle T, done at T+3.
  - Write with wbusy low: done at T+3.
  - Each extra rbusy/wbusy cycle adds 1.
- Requester rules:
  - m<g>_rdata holds its value until that requester's next read completes.
  - The other requester's rdata is never disturbed.
  - A req still high in the cycle after done is treated as a new request; requesters drop req on the cycle after done.
- A req deasserted mid-access is ignored: the access still completes and done still pulses.
- Round-robin guarantees no starvation: with both requesting continuously, grants alternate 0,1,0,1.
- The non-granted requester receives no done and waits, with req held.

Test Plan:
- Single read: preload addr 0x100 = 0xDEADBEEF; m0_req with m0_addr=0x100, m0_wmask=0 → s_rstrb high for 1 cycle at T+1; m0_done at T+3; m0_rdata=0xDEADBEEF; m1_rdata stays 0.
- Single write: m1_req with m1_addr=0x40, wdata=0x12345678, wmask=4'b0011 → s_wmask=0011 for exactly 1 cycle; m1_done at T+3; a later read of 0x40 returns low half 0x5678.
- Contention: m0_req and m1_req raised in the same cycle and held → grant order 0,1,0,1 over 4 accesses; each done arrives 4 cycles apart.
- Busy stretching: s_rbusy held high for 5 cycles after ISSUE → done at T+8; data captured only after rbusy falls.
- Timeout: TIMEOUT_CYCLES=8, s_wbusy stuck high → m0_done and m0_err pulse together; state returns to IDLE; a following m1 access completes normally.
- Async reset asserted in WAIT_R → all outputs 0 immediately; no done; after release, m0 wins the first tie.
